regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (write_en / write_address_0 / write_data) between NUM_REQ writeback sources: ALU writeback, load writeback, and the HI/LO mult/div unit.
- Arbitration is fixed priority with anti-starvation aging.
- Transfers use a valid/ready handshake with one registered cycle to the register file.
- Exports a pending-write mask so the hazard unit can stall reads of registers with queued writes.

Parameters:
- NUM_REQ, 3, number of writeback requesters; index 0 is highest priority.
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- STARVE_LIMIT, 4, consecutive lost cycles after which a waiting requester is promoted; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_address  input  NUM_REQ*ADDR_W  packed destination addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  packed write data; requester i uses slice [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant, combinational from the current-cycle inputs and state.
- write_en  output  1  register-file write enable.
- write_address_0  output  ADDR_W  register-file write address.
- write_data  output  DATA_W  register-file write data.
- grant_id  output  2  index of the requester whose write is currently on the port.
- pending_mask  output  32  bit k set when any valid, ungranted request targets register k.

Behaviour:
- Reset (clk edge with reset=1):
  - write_en=0, write_address_0=0, write_data=0, grant_id=0.
  - All starve counters cleared to 0.
  - Reset mid-transfer discards the in-flight registered write; no write_en pulse follows reset.
- Handshake:
  - A transfer occurs on an edge where req_valid[i] and req_ready[i] are both 1.
  - A requester holds valid, address and data stable until ready; dropping valid before ready is legal (request withdrawn).
  - At most one req_ready bit is high per cycle; req_ready is 0 for any requester whose valid is low.
- Arbitration, combinational each cycle:
  - Starved requester: starve_cnt[i] >= STARVE_LIMIT and valid.
  - If any starved requester exists, the lowest-index starved requester wins.
  - Otherwise the lowest-index valid requester wins.
- Starve counters, per requester:
  - valid and not granted: increment, saturating at 15.
  - Granted, or not valid: clear to 0.
- Output latency, exactly 1 cycle:
  - On a handshake edge, write_en is set to 1; write_address_0, write_data and grant_id take the winner's values.
  - With no handshake, write_en is set to 0; address, data and grant_id hold their last values.
  - Back-to-back grants produce write_en high on consecutive cycles.
- Register 0:
  - A request to address 0 is granted normally (ready=1) and consumes the port slot.
  - write_en stays 0 for that slot; address and data still update.
  - pending_mask bit 0 is always 0.
- pending_mask:
  - OR of the one-hot decoded req_address[i] over all i with req_valid[i]=1 and req_ready[i]=0.
  - Combinational, same cycle.
- Same-address collisions:
  - Two requesters targeting the same register are serialised in grant order.
  - The later grant's data is the final register contents.
- Widths: grant_id is zero-extended from the internal index; behaviour is undefined for NUM_REQ > 4.

Optional Feature:
- Macro: REGFILE_ARB_COMB_OUT_EN.
- Defined:
  - write_en, write_address_0, write_data and grant_id are driven combinationally from the current winner (0-cycle latency).
  - write_en = |(req_valid & req_ready) && winner address != 0.
  - Outputs are 0 during reset.
- Undefined: registered 1-cycle path as described above.
- Arbitration, starve counters and pending_mask are identical in both builds.

Test Plan:
- Single request:
  - Stimulus: req 1 valid, address 5, data 35, from idle.
  - Response: req_ready=3'b010 the same cycle; next cycle write_en=1, write_address_0=5, write_data=35, grant_id=1; write_en=0 the cycle after.
- Contention:
  - Stimulus: reqs 0 and 2 valid in the same cycle, addresses 3 and 7.
  - Response: req 0 wins first; pending_mask=32'h80 during that cycle; req 2 is written one cycle after req 0.
- Starvation (STARVE_LIMIT=4):
  - Stimulus: req 0 continuously valid with new data; req 2 valid, address 9.
  - Response: req 2 gets ready on its 5th valid cycle; req 0 is blocked for that one cycle.
- Register 0:
  - Stimulus: req 0 to address 0, data 32'hDEAD.
  - Response: req_ready[0]=1; write_en stays 0; pending_mask stays 0.
- Reset:
  - Stimulus: reset asserted on the edge right after a handshake (address 4).
  - Response: no write_en pulse; all outputs 0; starve counters 0.
- Withdraw:
  - Stimulus: req 1 valid for 2 losing cycles, then valid drops.
  - Response: starve_cnt[1] clears; no write to its address occurs.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writeback sources onto the single register-file write port.
// Define REGFILE_ARB_COMB_OUT_EN to drive the write port combinationally (0-cycle latency).
module regfile_write_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      write_en,
    output logic [ADDR_W-1:0]         write_address_0,
    output logic [DATA_W-1:0]         write_data,
    output logic [1:0]                grant_id,
    output logic [31:0]               pending_mask
);

    logic [3:0]         starve_q [NUM_REQ];
    logic [3:0]         starve_d [NUM_REQ];
    logic [NUM_REQ-1:0] starved;
    logic               win_any;
    logic [1:0]         win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               handshake;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            starved[i] = req_valid[i] && (starve_q[i] >= 4'(STARVE_LIMIT));
        end
    end

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        win_any = |req_valid;
        win_idx = '0;
        if (|starved) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (starved[i]) win_idx = 2'(i);
            end
        end else begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid[i]) win_idx = 2'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        win_addr  = '0;
        win_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_any && (win_idx == 2'(i))) begin
                req_ready[i] = 1'b1;
                win_addr     = req_address[i*ADDR_W +: ADDR_W];
                win_data     = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign handshake = |(req_valid & req_ready);

    // Register 0 is hardwired, so a queued write to it never needs a stall.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
                pending_mask[req_address[i*ADDR_W +: ADDR_W]] = 1'b1;
            end
        end
        pending_mask[0] = 1'b0;
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !req_ready[i]) begin
                starve_d[i] = (starve_q[i] == 4'hF) ? 4'hF : starve_q[i] + 4'd1;
            end else begin
                starve_d[i] = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                starve_q[i] <= 4'd0;
            end else begin
                starve_q[i] <= starve_d[i];
            end
        end
    end

`ifdef REGFILE_ARB_COMB_OUT_EN
    always_comb begin
        write_en        = 1'b0;
        write_address_0 = '0;
        write_data      = '0;
        grant_id        = '0;
        if (!reset && handshake) begin
            write_en        = (win_addr != '0);
            write_address_0 = win_addr;
            write_data      = win_data;
            grant_id        = win_idx;
        end
    end
`else
    logic              write_en_q;
    logic [ADDR_W-1:0] write_addr_q;
    logic [DATA_W-1:0] write_data_q;
    logic [1:0]        grant_id_q;

    // Address/data/id hold their last values when idle; only the enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            grant_id_q   <= '0;
        end else if (handshake) begin
            write_en_q   <= (win_addr != '0);
            write_addr_q <= win_addr;
            write_data_q <= win_data;
            grant_id_q   <= win_idx;
        end else begin
            write_en_q   <= 1'b0;
        end
    end

    assign write_en        = write_en_q;
    assign write_address_0 = write_addr_q;
    assign write_data      = write_data_q;
    assign grant_id        = grant_id_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter (default registered-output build).
module tb_regfile_write_arbiter;

    localparam int NUM_REQ      = 3;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      write_en;
    logic [ADDR_W-1:0]         write_address_0;
    logic [DATA_W-1:0]         write_data;
    logic [1:0]                grant_id;
    logic [31:0]               pending_mask;

    regfile_write_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_address    (req_address),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .write_en       (write_en),
        .write_address_0(write_address_0),
        .write_data     (write_data),
        .grant_id       (grant_id),
        .pending_mask   (pending_mask)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Requester-side stimulus state
    logic [NUM_REQ-1:0] v;
    logic [ADDR_W-1:0]  a [NUM_REQ];
    logic [DATA_W-1:0]  d [NUM_REQ];

    // Reference model state
    int                 starve [NUM_REQ];
    int                 win;
    logic [NUM_REQ-1:0] exp_ready;
    logic [31:0]        exp_mask;
    logic               exp_we;
    logic [ADDR_W-1:0]  exp_addr;
    logic [DATA_W-1:0]  exp_data;
    logic [1:0]         exp_gid;

    task automatic model_arb();
        win = -1;
        for (int i = 0; i < NUM_REQ; i++)
            if (win < 0 && v[i] && starve[i] >= STARVE_LIMIT) win = i;
        for (int i = 0; i < NUM_REQ; i++)
            if (win < 0 && v[i]) win = i;
        exp_ready = '0;
        if (win >= 0) exp_ready[win] = 1'b1;
        exp_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (v[i] && i != win) exp_mask[a[i]] = 1'b1;
        exp_mask[0] = 1'b0;
    endtask

    task automatic model_clock();
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) starve[i] = 0;
            exp_we = 1'b0; exp_addr = '0; exp_data = '0; exp_gid = '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++)
                starve[i] = (v[i] && i != win) ? ((starve[i] >= 15) ? 15 : starve[i] + 1) : 0;
            if (win >= 0) begin
                exp_we = (a[win] != '0); exp_addr = a[win]; exp_data = d[win]; exp_gid = 2'(win);
            end else begin
                exp_we = 1'b0;
            end
        end
    endtask

    task automatic apply();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i] = v[i];
            req_address[i*ADDR_W +: ADDR_W] = a[i];
            req_data[i*DATA_W +: DATA_W] = d[i];
        end
        #1;
        model_arb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        model_arb();
    endtask

    task automatic test_reset();
        reset = 1'b1; v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin a[i] = '0; d[i] = '0; starve[i] = 0; end
        apply(); tick(); tick();
        checks++; if (write_en !== 1'b0) begin failures++;
            $display("FAIL reset_we: got %b expected 0", write_en); end
        checks++; if (write_address_0 !== 5'd0 || write_data !== 32'd0 || grant_id !== 2'd0) begin
            failures++; $display("FAIL reset_outs: got addr=%h data=%h gid=%0d expected 0",
                                 write_address_0, write_data, grant_id); end
        checks++; if (req_ready !== 3'b000 || pending_mask !== 32'd0) begin failures++;
            $display("FAIL reset_idle: got ready=%b mask=%h expected 0", req_ready, pending_mask); end
        reset = 1'b0;
        apply();
    endtask

    task automatic test_single();
        v[1] = 1'b1; a[1] = 5'd5; d[1] = 32'd35;
        apply();
        checks++; if (req_ready !== 3'b010) begin failures++;
            $display("FAIL single_ready: got %b expected 010", req_ready); end
        tick();
        checks++; if (write_en !== 1'b1 || write_address_0 !== 5'd5 || write_data !== 32'd35
                      || grant_id !== 2'd1) begin failures++;
            $display("FAIL single_write: got we=%b addr=%0d data=%0d gid=%0d expected 1/5/35/1",
                     write_en, write_address_0, write_data, grant_id); end
        v[1] = 1'b0;
        apply(); tick();
        checks++; if (write_en !== 1'b0 || write_address_0 !== 5'd5) begin failures++;
            $display("FAIL single_after: got we=%b addr=%0d expected 0/5", write_en, write_address_0); end
    endtask

    task automatic test_contention();
        v[0] = 1'b1; a[0] = 5'd3; d[0] = 32'h1111;
        v[2] = 1'b1; a[2] = 5'd7; d[2] = 32'h2222;
        apply();
        checks++; if (req_ready !== 3'b001 || pending_mask !== 32'h80) begin failures++;
            $display("FAIL cont_first: got ready=%b mask=%h expected 001/80", req_ready, pending_mask); end
        tick();
        v[0] = 1'b0;
        apply();
        checks++; if (write_en !== 1'b1 || write_address_0 !== 5'd3 || grant_id !== 2'd0) begin
            failures++; $display("FAIL cont_w0: got we=%b addr=%0d gid=%0d expected 1/3/0",
                                 write_en, write_address_0, grant_id); end
        checks++; if (req_ready !== 3'b100 || pending_mask !== 32'd0) begin failures++;
            $display("FAIL cont_second: got ready=%b mask=%h expected 100/0", req_ready, pending_mask); end
        tick();
        checks++; if (write_en !== 1'b1 || write_address_0 !== 5'd7 || write_data !== 32'h2222
                      || grant_id !== 2'd2) begin failures++;
            $display("FAIL cont_w2: got we=%b addr=%0d data=%h gid=%0d expected 1/7/2222/2",
                     write_en, write_address_0, write_data, grant_id); end
        v[2] = 1'b0;
        apply(); tick();
    endtask

    task automatic test_starvation();
        int got = -1;
        v[0] = 1'b1; a[0] = 5'd1;
        v[2] = 1'b1; a[2] = 5'd9; d[2] = 32'h9999;
        for (int n = 1; n <= 8; n++) begin
            d[0] = $urandom;
            apply();
            checks++; if (req_ready !== exp_ready) begin failures++;
                $display("FAIL starve_ready[%0d]: got %b expected %b", n, req_ready, exp_ready); end
            if (got < 0 && req_ready[2]) got = n;
            tick();
            checks++; if (write_en !== exp_we || write_address_0 !== exp_addr
                          || write_data !== exp_data || grant_id !== exp_gid) begin failures++;
                $display("FAIL starve_out[%0d]: got %b/%0d/%h/%0d expected %b/%0d/%h/%0d", n,
                         write_en, write_address_0, write_data, grant_id,
                         exp_we, exp_addr, exp_data, exp_gid); end
            if (got == n) v[2] = 1'b0;
        end
        checks++; if (got != 5) begin failures++;
            $display("FAIL starve_cycle: got grant on valid cycle %0d expected 5", got); end
        v[0] = 1'b0;
        apply(); tick();
    endtask

    task automatic test_reg0();
        v[0] = 1'b1; a[0] = 5'd0; d[0] = 32'hDEAD;
        v[1] = 1'b1; a[1] = 5'd0; d[1] = 32'hBEEF;
        apply();
        checks++; if (req_ready !== 3'b001 || pending_mask !== 32'd0) begin failures++;
            $display("FAIL reg0_arb: got ready=%b mask=%h expected 001/0", req_ready, pending_mask); end
        tick();
        checks++; if (write_en !== 1'b0 || write_address_0 !== 5'd0 || write_data !== 32'hDEAD) begin
            failures++; $display("FAIL reg0_out: got we=%b addr=%0d data=%h expected 0/0/dead",
                                 write_en, write_address_0, write_data); end
        v[0] = 1'b0;
        apply();
        checks++; if (req_ready !== 3'b010) begin failures++;
            $display("FAIL reg0_next: got %b expected 010", req_ready); end
        tick();
        checks++; if (write_en !== 1'b0 || write_data !== 32'hBEEF || grant_id !== 2'd1) begin
            failures++; $display("FAIL reg0_out2: got we=%b data=%h gid=%0d expected 0/beef/1",
                                 write_en, write_data, grant_id); end
        v[1] = 1'b0;
        apply(); tick();
    endtask

    task automatic test_reset_mid();
        // Handshake coinciding with a reset edge is discarded.
        v[1] = 1'b1; a[1] = 5'd4; d[1] = 32'h44;
        reset = 1'b1;
        apply(); tick();
        reset = 1'b0; v[1] = 1'b0;
        apply();
        checks++; if (write_en !== 1'b0 || write_address_0 !== 5'd0 || write_data !== 32'd0) begin
            failures++; $display("FAIL rst_drop: got we=%b addr=%0d data=%h expected 0/0/0",
                                 write_en, write_address_0, write_data); end
        // Build up req 2 starvation, then reset; it must start over from zero.
        v[0] = 1'b1; a[0] = 5'd4; v[2] = 1'b1; a[2] = 5'd8; d[2] = 32'h88;
        for (int n = 0; n < 6; n++) begin
            reset = (n == 3);
            d[0] = $urandom;
            apply();
            checks++; if (req_ready !== exp_ready || pending_mask !== exp_mask) begin failures++;
                $display("FAIL rst_arb[%0d]: got %b/%h expected %b/%h", n, req_ready, pending_mask,
                         exp_ready, exp_mask); end
            tick();
            checks++; if (write_en !== exp_we || write_address_0 !== exp_addr
                          || write_data !== exp_data) begin failures++;
                $display("FAIL rst_out[%0d]: got %b/%0d/%h expected %b/%0d/%h", n, write_en,
                         write_address_0, write_data, exp_we, exp_addr, exp_data); end
        end
        reset = 1'b0; v = '0;
        apply(); tick();
    endtask

    task automatic test_withdraw();
        v[0] = 1'b1; a[0] = 5'd2; d[0] = 32'h22;
        for (int n = 0; n < 7; n++) begin
            v[1] = (n != 2); a[1] = 5'd6; d[1] = 32'h66;
            apply();
            checks++; if (req_ready !== 3'b001) begin failures++;
                $display("FAIL withdraw_ready[%0d]: got %b expected 001", n, req_ready); end
            tick();
            checks++; if (write_address_0 !== 5'd2 || write_en !== 1'b1) begin failures++;
                $display("FAIL withdraw_out[%0d]: got we=%b addr=%0d expected 1/2", n, write_en,
                         write_address_0); end
        end
        v = '0;
        apply(); tick();
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] gnt;
        for (int n = 0; n < 500; n++) begin
            reset = ($urandom_range(0, 63) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (v[i] && $urandom_range(0, 9) == 0) v[i] = 1'b0;
                if (!v[i] && $urandom_range(0, 2) != 0) begin
                    v[i] = 1'b1; a[i] = 5'($urandom_range(0, 7)); d[i] = $urandom;
                end
            end
            apply();
            checks++; if (req_ready !== exp_ready || pending_mask !== exp_mask) begin failures++;
                $display("FAIL rand_arb[%0d]: got %b/%h expected %b/%h", n, req_ready,
                         pending_mask, exp_ready, exp_mask); end
            gnt = exp_ready;
            tick();
            checks++; if (write_en !== exp_we || write_address_0 !== exp_addr
                          || write_data !== exp_data || grant_id !== exp_gid) begin failures++;
                $display("FAIL rand_out[%0d]: got %b/%0d/%h/%0d expected %b/%0d/%h/%0d", n,
                         write_en, write_address_0, write_data, grant_id,
                         exp_we, exp_addr, exp_data, exp_gid); end
            v = v & ~gnt;
        end
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_starvation();
        test_reg0();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
